morse_sequencer: RTL and testbench

//  Consumes the up-to-8 digit codes produced by the keypad entry stage: 5-bit Morse codes r0..r7, plus the digit count.
//  On a start pulse it snapshots them and plays them in order as Morse timing on tone_en and a square-wave buzzer output.

---
 rtl/morse_sequencer.sv | 167 ++++++++++++++++
 tb/tb_morse_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_sequencer.sv
// Morse playback sequencer.
// Captures up to eight 5-bit Morse digit codes plus a digit count on a start pulse.
// Plays the captured codes as Morse timing on tone_en, with a square-wave buzz during each mark.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   start, abort     1-cycle play request; immediate stop (abort has priority)
//   count            number of valid digits; values above 8 are clamped to 8
//   r0..r7           per-digit code, MSB sent first; 1 = dash, 0 = dot
//   tone_en, buzz    mark indicator; square wave while marking
//   busy, digit_idx  playback in progress; index of the digit being sent
//   done             1-cycle pulse after the final mark
module morse_sequencer #(
  parameter int unsigned UNIT_CYCLES = 25_000_000,
  parameter int unsigned TONE_HALF   = 25_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] count,
  input  logic [4:0] r0,
  input  logic [4:0] r1,
  input  logic [4:0] r2,
  input  logic [4:0] r3,
  input  logic [4:0] r4,
  input  logic [4:0] r5,
  input  logic [4:0] r6,
  input  logic [4:0] r7,
  output logic       tone_en,
  output logic       buzz,
  output logic       busy,
  output logic [2:0] digit_idx,
  output logic       done
);

  localparam int unsigned TW = $clog2(3 * UNIT_CYCLES);
  localparam int unsigned HW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [TW-1:0] DotLoad  = TW'(UNIT_CYCLES - 1);
  localparam logic [TW-1:0] DashLoad = TW'(3 * UNIT_CYCLES - 1);
  localparam logic [HW-1:0] ToneLast = HW'(TONE_HALF - 1);

  typedef enum logic [2:0] {StIdle, StMark, StSpace, StDgap, StFin} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      bit_q, bit_d;
  logic [HW-1:0]   tone_cnt_q, tone_cnt_d;
  logic            buzz_q, buzz_d;
  logic [7:0][4:0] codes_q;
  logic [3:0]      n_q;
  logic            snap;
  logic [3:0]      count_sat;
  logic            cur_dash;
  logic            last_digit;

  assign count_sat  = (count > 4'd8) ? 4'd8 : count;
  // Symbol selected by the already-advanced idx/bit, i.e. the mark about to start.
  assign cur_dash   = codes_q[idx_q][bit_q];
  assign last_digit = (({1'b0, idx_q} + 4'd1) == n_q);

  always_comb begin
    state_d = state_q;
    timer_d = (timer_q != '0) ? timer_q - TW'(1) : '0;
    idx_d   = idx_q;
    bit_d   = bit_q;
    snap    = 1'b0;
    if (abort) begin
      state_d = StIdle;
      timer_d = '0;
      idx_d   = '0;
      bit_d   = 3'd4;
    end else begin
      case (state_q)
        StIdle: begin
          timer_d = '0;
          if (start) begin
            snap  = 1'b1;
            idx_d = '0;
            bit_d = 3'd4;
            if (count_sat == 4'd0) begin
              state_d = StFin;
            end else begin
              state_d = StMark;
              timer_d = r0[4] ? DashLoad : DotLoad;
            end
          end
        end
        StMark: begin
          if (timer_q == '0) begin
            if (bit_q != 3'd0) begin
              bit_d   = bit_q - 3'd1;
              state_d = StSpace;
              timer_d = DotLoad;
            end else if (last_digit) begin
              state_d = StFin;
            end else begin
              idx_d   = idx_q + 3'd1;
              bit_d   = 3'd4;
              state_d = StDgap;
              timer_d = DashLoad;
            end
          end
        end
        StSpace, StDgap: begin
          if (timer_q == '0) begin
            state_d = StMark;
            timer_d = cur_dash ? DashLoad : DotLoad;
          end
        end
        StFin: begin
          state_d = StIdle;
          idx_d   = '0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Tone phase restarts at every mark entry so each mark begins with buzz low.
  always_comb begin
    tone_cnt_d = '0;
    buzz_d     = 1'b0;
    if (state_q == StMark && state_d == StMark) begin
      if (tone_cnt_q == ToneLast) begin
        buzz_d = ~buzz_q;
      end else begin
        tone_cnt_d = tone_cnt_q + HW'(1);
        buzz_d     = buzz_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      idx_q      <= '0;
      bit_q      <= 3'd4;
      tone_cnt_q <= '0;
      buzz_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      bit_q      <= bit_d;
      tone_cnt_q <= tone_cnt_d;
      buzz_q     <= buzz_d;
    end
  end

  // Snapshot of the entry; contents are only meaningful after a start.
  always_ff @(posedge clk) begin
    if (snap) begin
      codes_q <= {r7, r6, r5, r4, r3, r2, r1, r0};
      n_q     <= count_sat;
    end
  end

  assign tone_en   = (state_q == StMark);
  assign buzz      = buzz_q && (state_q == StMark);
  assign busy      = (state_q == StMark) || (state_q == StSpace) || (state_q == StDgap);
  assign done      = (state_q == StFin);
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_morse_sequencer.sv
module tb_morse_sequencer;

  localparam int unsigned Unit = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] count;
  logic [4:0] r [8];
  logic       tone_en;
  logic       buzz;
  logic       busy;
  logic [2:0] digit_idx;
  logic       done;

  int checks = 0;
  int errors = 0;

  // kind: 0 = mark, 1 = low gap while busy, 2 = done (len = gap cycles before done)
  typedef struct {
    int kind;
    int len;
    int idx;
  } ev_t;
  ev_t exp_q[$];

  morse_sequencer #(
    .UNIT_CYCLES(Unit),
    .TONE_HALF  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .count    (count),
    .r0       (r[0]),
    .r1       (r[1]),
    .r2       (r[2]),
    .r3       (r[3]),
    .r4       (r[4]),
    .r5       (r[5]),
    .r6       (r[6]),
    .r7       (r[7]),
    .tone_en  (tone_en),
    .buzz     (buzz),
    .busy     (busy),
    .digit_idx(digit_idx),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int kind, input int len, input int idx);
    ev_t e;
    e.kind = kind;
    e.len  = len;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  // Five marks of one digit with the intra-digit spaces between them.
  task automatic push_digit(input logic [4:0] code, input int d);
    for (int b = 4; b >= 0; b--) begin
      push(0, code[b] ? 3 * Unit : Unit, d);
      if (b > 0) push(1, Unit, d);
    end
  endtask

  task automatic expect_play(input int n);
    for (int d = 0; d < n; d++) begin
      push_digit(r[d], d);
      if (d < n - 1) push(1, 3 * Unit, d + 1);
    end
    push(2, 0, 0);
  endtask

  task automatic check_ev(input int kind, input int len, input int idx);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d len=%0d idx=%0d", kind, len, idx);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.len != len || (kind != 2 && e.idx != idx)) begin
        errors++;
        $display("FAIL event got kind=%0d len=%0d idx=%0d want kind=%0d len=%0d idx=%0d",
                 kind, len, idx, e.kind, e.len, e.idx);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout got none want done within %0d cycles", limit);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Monitor: turns the output waveform into mark/gap/done events and checks buzz each cycle.
  int mark_cnt = 0;
  int mark_idx = 0;
  int gap_cnt  = 0;
  bit prev_tone = 1'b0;

  always @(negedge clk) begin
    chk("buzz", int'(buzz), tone_en ? (mark_cnt % 2) : 0);
    if (tone_en) begin
      if (!prev_tone && gap_cnt > 0) check_ev(1, gap_cnt, int'(digit_idx));
      gap_cnt  = 0;
      mark_cnt++;
      mark_idx = int'(digit_idx);
    end else begin
      if (prev_tone) check_ev(0, mark_cnt, mark_idx);
      mark_cnt = 0;
      if (busy) gap_cnt++;
    end
    if (done) check_ev(2, gap_cnt, 0);
    if (!busy) gap_cnt = 0;
    prev_tone = tone_en;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    count = 4'd0;
    for (int i = 0; i < 8; i++) r[i] = 5'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tone", int'(tone_en), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_idx", int'(digit_idx), 0);
    rst = 1'b0;
    tick();

    // "5": five dots; later input changes and a start during playback are ignored.
    count = 4'd1;
    r[0]  = 5'b00000;
    expect_play(1);
    pulse_start();
    chk("first_tone", int'(tone_en), 1);
    chk("first_busy", int'(busy), 1);
    r[0]  = 5'b11111;
    count = 4'd3;
    repeat (10) tick();
    pulse_start();
    wait_done(200);
    tick();
    chk("q_empty_5", exp_q.size(), 0);

    // "0": five dashes.
    count = 4'd1;
    r[0]  = 5'b11111;
    expect_play(1);
    pulse_start();
    wait_done(300);
    tick();
    chk("q_empty_0", exp_q.size(), 0);

    // "14": inter-digit gap with index change.
    count = 4'd2;
    r[0]  = 5'b01111;
    r[1]  = 5'b00001;
    expect_play(2);
    pulse_start();
    wait_done(400);
    tick();
    chk("q_empty_14", exp_q.size(), 0);
    chk("idle_idx", int'(digit_idx), 0);

    // count = 0: done next cycle, no tone.
    count = 4'd0;
    push(2, 0, 0);
    pulse_start();
    chk("cnt0_done", int'(done), 1);
    chk("cnt0_tone", int'(tone_en), 0);
    tick();
    chk("q_empty_cnt0", exp_q.size(), 0);

    // count = 9 clamps to 8 digits.
    count = 4'd9;
    r[0] = 5'b00000; r[1] = 5'b11111; r[2] = 5'b01010; r[3] = 5'b10101;
    r[4] = 5'b00011; r[5] = 5'b11000; r[6] = 5'b00111; r[7] = 5'b10000;
    expect_play(8);
    pulse_start();
    wait_done(2000);
    tick();
    chk("q_empty_cnt9", exp_q.size(), 0);

    // Abort three cycles into the second dash of "0", then replay.
    count = 4'd1;
    r[0]  = 5'b11111;
    push(0, 3 * Unit, 0);
    push(1, Unit, 0);
    push(0, 3, 0);
    pulse_start();
    repeat (18) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_tone", int'(tone_en), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (20) tick();
    chk("q_empty_abort", exp_q.size(), 0);
    expect_play(1);
    pulse_start();
    wait_done(300);
    tick();
    chk("q_empty_replay", exp_q.size(), 0);

    // Start and abort together: nothing plays.
    r[0]  = 5'b00000;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", int'(busy), 0);
    repeat (10) tick();
    chk("sa_tone", int'(tone_en), 0);

    // Async reset in the middle of the inter-digit gap of "14".
    count = 4'd2;
    r[0]  = 5'b01111;
    r[1]  = 5'b00001;
    push_digit(r[0], 0);
    pulse_start();
    repeat (72) tick();
    chk("dgap_idx", int'(digit_idx), 1);
    chk("dgap_busy", int'(busy), 1);
    chk("dgap_tone", int'(tone_en), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_idx", int'(digit_idx), 0);
    chk("arst_tone", int'(tone_en), 0);
    chk("arst_buzz", int'(buzz), 0);
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("post_rst_busy", int'(busy), 0);
    chk("q_empty_rst", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
